// File: rtl/btn_pkg.sv
// Shared constants for the push-button debounce stage.
// Holds the debounce FSM state codes and the default debounce length.
package btn_pkg;

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_HELD         = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   localparam int DB_CYCLES_DEFAULT = 16;

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Both stages clear on a synchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule : sync_2ff

// File: rtl/btn_debounce_pulse.sv
// Debounces a bouncing button level and emits one count-enable strobe
// per accepted press; the level and strobe are both registered.
module btn_debounce_pulse
   import btn_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int CNT_W     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic en,
   output logic btn_level,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync_in;
   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             level_q,  level_d;
   logic             pulse_q,  pulse_d;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (sync_in)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync_in) begin
               state_d = ST_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!sync_in) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               pulse_d = en;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!sync_in) begin
               state_d = ST_RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         default: begin
            // A bounce back high returns to HELD without a fresh strobe.
            if (sync_in) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
      level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
      end
   end

   assign btn_level = level_q;
   assign pulse     = pulse_q;

endmodule : btn_debounce_pulse

// File: tb/tb_btn_debounce_pulse.sv
// Randomised and directed bench for btn_debounce_pulse with DB_CYCLES=4,
// checked every cycle against a run-length model of the debounce rules.
module tb_btn_debounce_pulse;

   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_raw = 1'b0;
   logic en = 1'b1;
   logic btn_level;
   logic pulse;

   always #5 clk = ~clk;

   btn_debounce_pulse #(.DB_CYCLES(DB), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .en        (en),
      .btn_level (btn_level),
      .pulse     (pulse)
   );

   int total = 0;
   int bad   = 0;

   // Model: raw history (two-edge delay), run of edges disagreeing with level.
   bit m_h1, m_h2, m_level, m_pulse;
   int m_run;
   int dut_pulses;
   int counter_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit rs);
      bit sync;
      if (rs) begin
         m_h1 = 0; m_h2 = 0; m_run = 0; m_level = 0; m_pulse = 0;
      end else begin
         sync = m_h2;
         m_h2 = m_h1;
         m_h1 = r;
         m_pulse = 0;
         if (sync != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
               m_level = sync;
               m_run   = 0;
               m_pulse = sync & e;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit rs);
      @(negedge clk);
      btn_raw = r;
      en      = e;
      rst     = rs;
      @(posedge clk);
      model_edge(r, e, rs);
      #1;
      check("level", btn_level, m_level);
      check("pulse", pulse, m_pulse);
      if (pulse === 1'b1) begin
         dut_pulses++;
         counter_q++;
      end
   endtask

   // Holds raw at r for n cycles; returns first index where level == r and pulse count.
   task automatic hold(input bit r, input bit e, input int n, output int first, output int npulse);
      int p0;
      p0 = dut_pulses;
      first = -1;
      for (int i = 0; i < n; i++) begin
         step(r, e, 1'b0);
         if (first < 0 && btn_level === r) first = i;
      end
      npulse = dut_pulses - p0;
   endtask

   initial begin
      int first, np, p0, len;
      bit r;
      m_h1 = 0; m_h2 = 0; m_level = 0; m_pulse = 0; m_run = 0;
      dut_pulses = 0; counter_q = 0;

      step(0, 1, 1);
      step(0, 1, 1);
      check("rst_level", btn_level, 1'b0);
      check("rst_pulse", pulse, 1'b0);
      hold(0, 1, 5, first, np);

      hold(1, 1, 20, first, np);
      check("clean_rise_at", first, 6);
      check("clean_pulses", np, 1);
      hold(0, 1, 12, first, np);
      check("clean_fall_at", first, 6);
      $display("scenario clean press/release done");

      p0 = dut_pulses;
      step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
      hold(1, 1, 20, first, np);
      check("pbounce_pulses", dut_pulses - p0, 1);
      $display("scenario press bounce done");

      p0 = dut_pulses;
      step(0, 1, 0); step(0, 1, 0); step(1, 1, 0);
      check("rbounce_level", btn_level, 1'b1);
      hold(0, 1, 12, first, np);
      check("rbounce_fall_at", first, 6);
      check("rbounce_pulses", dut_pulses - p0, 0);
      $display("scenario release bounce done");

      hold(1, 0, 12, first, np);
      check("en0_rise_at", first, 6);
      check("en0_pulses", np, 0);
      for (int i = 0; i < 6; i++) step(1, i[0], 0);
      check("held_en_toggle", dut_pulses, 2);
      hold(0, 1, 12, first, np);
      hold(1, 1, 12, first, np);
      check("en1_pulses", np, 1);
      hold(0, 1, 12, first, np);
      $display("scenario enable gating done");

      for (int i = 0; i < 5; i++) step(1, 1, 0);
      step(1, 1, 1);
      check("midrst_level", btn_level, 1'b0);
      check("midrst_pulse", pulse, 1'b0);
      hold(1, 1, 12, first, np);
      check("midrst_rise_at", first, 6);
      check("midrst_pulses", np, 1);
      hold(0, 1, 12, first, np);
      $display("scenario reset mid-debounce done");

      counter_q = 0;
      for (int i = 0; i < 5; i++) begin
         hold(1, 1, 10, first, np);
         hold(0, 1, 10, first, np);
      end
      check("chain_counter", counter_q, 5);
      $display("scenario chained counter done value=%0d", counter_q);

      p0 = dut_pulses;
      r = 0;
      for (int blk = 0; blk < 400; blk++) begin
         len = $urandom_range(1, 9);
         r = ~r;
         for (int j = 0; j < len; j++)
            step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
      end
      $display("scenario random done pulses=%0d", dut_pulses - p0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_btn_debounce_pulse
